set_mode_ctrl: RTL
==================

# set_mode_ctrl

Two-key time/date setting sequencer for the clock-calendar top level. Debounces a MODE key and an INC key and walks a setting state machine through hour, minute, year, month and day. It emits one-cycle increment strobes to the matching counter (time counters and calendar), plus display blink and date-view select. It replaces the five independent adjust keys with a single sequenced control path; the counters themselves are unchanged.

## Interface
Parameters:
- DEBOUNCE_MS, 20: consecutive equal 1 kHz samples needed to accept a key level change (1–255)
- REPEAT_DELAY_MS, 600: INC hold time before first auto-repeat
- REPEAT_RATE_MS, 150: auto-repeat interval after the first repeat
- TIMEOUT_MS, 10000: idle time in any SET state before returning to RUN (≤16383)
- BLINK_HALF_MS, 250: blink half-period

Ports:
- CLK_50  in  1  system clock, all logic on rising edge
- CR  in  1  reset, asynchronous, active-high
- tick_1k  in  1  one-CLK_50-cycle strobe at 1 kHz; all ms timing counts these
- mode_key  in  1  raw MODE key, active-high, asynchronous to CLK_50
- inc_key  in  1  raw INC key, active-high, asynchronous
- adj_hr  out  1  one-cycle hour increment strobe
- adj_min  out  1  one-cycle minute increment strobe
- year_add  out  1  one-cycle year increment strobe
- month_add  out  1  one-cycle month increment strobe
- day_add  out  1  one-cycle day increment strobe
- blink_mask  out  5  {hr,min,year,mon,day}; 1 = blank that field's digits
- flag  out  1  1 = display date view, 0 = time view
- setting  out  1  1 whenever state ≠ RUN

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer. The debouncer is evaluated only on tick_1k. It accepts a new level after DEBOUNCE_MS consecutive samples that differ from the accepted level. The counter clears on any sample equal to the accepted level.
- Press event = accepted level rising 0→1. Release produces no event.
- FSM states: RUN, SET_HR, SET_MIN, SET_YEAR, SET_MON, SET_DAY.
  - A MODE press advances RUN→SET_HR→SET_MIN→SET_YEAR→SET_MON→SET_DAY→RUN (wrap).
- INC press in a SET state fires that state's strobe. INC in RUN is ignored; no strobe.
- MODE and INC press events on the same tick: MODE wins, INC is discarded.
- A held INC (auto-repeat, see Configuration) fires extra strobes while the state is unchanged.
  - A MODE press during a hold cancels repeat until INC is released and pressed again.
- Timeout counter:
  - cleared on entering any SET state and on every MODE/INC event, including repeats;
  - increments per tick in SET states;
  - at TIMEOUT_MS the FSM goes to RUN and no strobe is issued.
- flag = 1 in SET_YEAR, SET_MON, SET_DAY; 0 otherwise.
- Blink:
  - blink_phase toggles every BLINK_HALF_MS ticks;
  - it is forced to 0 and its counter cleared on every state entry and every strobe, so a field is visible immediately after it is adjusted;
  - blink_mask bit of the current SET field = blink_phase; all other bits 0; in RUN all 0.
- At most one strobe is high in any cycle. Strobes never assert in RUN.

## Timing
- Reset (CR=1, async): state RUN, all strobes 0, blink_mask 5'b0, flag 0, setting 0, all counters 0, accepted key levels 0, blink_phase 0.
- Latency: a strobe, state change, flag and setting all update on the CLK_50 edge following the tick_1k cycle in which the debouncer accepts the press (1 cycle). Each strobe is high exactly 1 CLK_50 cycle.
- Press-to-strobe: DEBOUNCE_MS ticks after the synchronized level changes (+2 cycles of synchronizer).
- CR asserted mid-hold or mid-setting: immediate return to reset values. A key still held at CR release must be released and re-pressed to generate an event.
- tick_1k high for more than 1 cycle is not supported. Behaviour is defined only for single-cycle ticks.

## Configuration
- SET_AUTOREPEAT_EN defined:
  - with INC held in a SET state, the first repeat strobe fires REPEAT_DELAY_MS ticks after the press event;
  - further strobes follow every REPEAT_RATE_MS ticks until release, state change or timeout.
- Not defined: exactly one strobe per press. Repeat counters are not implemented. REPEAT_* parameters are accepted but unused.

## Test plan
- Params DEBOUNCE_MS=3, TIMEOUT_MS=50, tick every 4 cycles: assert CR mid-run → all outputs 0 same cycle; 5 MODE presses → states HR, MIN, YEAR, MON, DAY, then RUN; flag=1 only in the three date states.
- SET_MIN, one clean INC press → exactly one adj_min pulse, 1 cycle wide, 1 cycle after the 3rd accepting tick. INC in RUN → no strobe.
- Bounce INC (1,0,1,0 per tick, then steady 1) → a single strobe, 3 ticks after the steady level begins.
- MODE and INC accepted on the same tick in SET_HR → state SET_MIN, no adj_hr.
- SET_DAY idle for 50 ticks → RUN, setting=0, no day_add. An INC at tick 49 restarts the 50-tick count.
- SET_AUTOREPEAT_EN, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=4, hold INC 30 ticks in SET_YEAR → strobes at 0, 10, 14, 18, 22, 26 ticks after the press event (6 total). Without the macro → 1 strobe.

Source files
------------

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl
//   Two-key setting sequencer for the clock-calendar. MODE walks the setting
//   state machine RUN -> HR -> MIN -> YEAR -> MON -> DAY -> RUN, and INC fires
//   a one-cycle increment strobe to the counter of the field being set.
//   An idle timeout returns to RUN. A blink phase drives the field blanking.
//
// Optional feature macro: SET_AUTOREPEAT_EN
//   Defined   : a held INC auto-repeats after REPEAT_DELAY_MS, then every
//               REPEAT_RATE_MS ticks.
//   Undefined : exactly one strobe per INC press; REPEAT_* unused.
//
// Ports
//   CLK_50      in   system clock, rising edge
//   CR          in   asynchronous active-high reset
//   tick_1k     in   single-cycle 1 kHz strobe; all ms timing counts it
//   mode_key    in   raw MODE key (asynchronous, active-high)
//   inc_key     in   raw INC key (asynchronous, active-high)
//   adj_hr      out  hour increment strobe
//   adj_min     out  minute increment strobe
//   year_add    out  year increment strobe
//   month_add   out  month increment strobe
//   day_add     out  day increment strobe
//   blink_mask  out  {hr,min,year,mon,day}; 1 blanks that field
//   flag        out  1 = date view
//   setting     out  1 whenever not in RUN
//
// Strobe contract: each increment strobe is a one-cycle pulse with no
// back-pressure; the counter must accept it in the cycle it is high. At most
// one strobe is high per cycle, and strobes never fire from RUN.
module set_mode_ctrl #(
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 600,
  parameter int unsigned REPEAT_RATE_MS  = 150,
  parameter int unsigned TIMEOUT_MS      = 10000,
  parameter int unsigned BLINK_HALF_MS   = 250
) (
  input  logic       CLK_50,
  input  logic       CR,
  input  logic       tick_1k,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic       adj_hr,
  output logic       adj_min,
  output logic       year_add,
  output logic       month_add,
  output logic       day_add,
  output logic [4:0] blink_mask,
  output logic       flag,
  output logic       setting
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_YEAR = 3'd3,
    SET_MON  = 3'd4,
    SET_DAY  = 3'd5
  } state_t;

  localparam logic [7:0]  DB_LIM = DEBOUNCE_MS[7:0];
  localparam logic [13:0] TO_LIM = TIMEOUT_MS[13:0];
  localparam logic [15:0] BL_LIM = BLINK_HALF_MS[15:0];

  // Key index 0 = MODE, 1 = INC.
  logic [1:0]      key_s1_q, key_s2_q;
  logic [1:0]      key_acc_q, key_acc_d;
  logic [1:0]      key_arm_q, key_arm_d;
  logic [1:0][7:0] db_cnt_q, db_cnt_d;
  logic [1:0]      key_press;

  state_t          state_q, state_d;
  logic [4:0]      strobe_q, strobe_d;
  logic [13:0]     to_cnt_q, to_cnt_d;
  logic [15:0]     bl_cnt_q, bl_cnt_d;
  logic            bl_phase_q, bl_phase_d;

  logic            mode_ev, inc_ev, is_set, rep_fire, timeout_hit, fire;

  function automatic logic [4:0] field_of(input state_t s);
    case (s)
      SET_HR:   field_of = 5'b10000;
      SET_MIN:  field_of = 5'b01000;
      SET_YEAR: field_of = 5'b00100;
      SET_MON:  field_of = 5'b00010;
      SET_DAY:  field_of = 5'b00001;
      default:  field_of = 5'b00000;
    endcase
  endfunction

  function automatic state_t next_mode(input state_t s);
    case (s)
      RUN:      next_mode = SET_HR;
      SET_HR:   next_mode = SET_MIN;
      SET_MIN:  next_mode = SET_YEAR;
      SET_YEAR: next_mode = SET_MON;
      SET_MON:  next_mode = SET_DAY;
      default:  next_mode = RUN;
    endcase
  endfunction

  // Debounce: a level is accepted after DB_LIM consecutive differing tick
  // samples. A key only becomes "armed" after a released sample has been
  // seen, so a key held through reset produces no press until re-pressed.
  always_comb begin
    key_acc_d = key_acc_q;
    key_arm_d = key_arm_q;
    db_cnt_d  = db_cnt_q;
    key_press = 2'b00;
    if (tick_1k) begin
      for (int k = 0; k < 2; k++) begin
        if (!key_s2_q[k]) key_arm_d[k] = 1'b1;
        if (key_s2_q[k] == key_acc_q[k]) begin
          db_cnt_d[k] = 8'd0;
        end else if (db_cnt_q[k] + 8'd1 == DB_LIM) begin
          key_acc_d[k] = key_s2_q[k];
          db_cnt_d[k]  = 8'd0;
          key_press[k] = key_s2_q[k] & key_arm_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign mode_ev = key_press[0];
  assign inc_ev  = key_press[1];
  assign is_set  = (state_q != RUN);

  // Any key event (press or repeat) restarts the idle count, so the timeout
  // only fires on a tick without one.
  assign timeout_hit = is_set & tick_1k & ~mode_ev & ~inc_ev & ~rep_fire &
                       (to_cnt_q + 14'd1 == TO_LIM);

`ifdef SET_AUTOREPEAT_EN
  localparam logic [15:0] RD_LIM = REPEAT_DELAY_MS[15:0];
  localparam logic [15:0] RR_LIM = REPEAT_RATE_MS[15:0];

  logic        rep_on_q, rep_on_d, rep_first_q, rep_first_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;

  assign rep_fire = tick_1k & rep_on_q & key_acc_q[1] & is_set & ~mode_ev &
                    (rep_cnt_q + 16'd1 == (rep_first_q ? RD_LIM : RR_LIM));

  // Repeat is armed only by a real INC press; MODE, timeout, leaving the SET
  // states or an accepted release all disarm it.
  always_comb begin
    rep_on_d    = rep_on_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    if (mode_ev || !is_set || timeout_hit) begin
      rep_on_d  = 1'b0;
      rep_cnt_d = 16'd0;
    end else if (inc_ev) begin
      rep_on_d    = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = 16'd0;
    end else if (rep_fire) begin
      rep_first_d = 1'b0;
      rep_cnt_d   = 16'd0;
    end else if (tick_1k && rep_on_q) begin
      if (!key_acc_q[1]) begin
        rep_on_d  = 1'b0;
        rep_cnt_d = 16'd0;
      end else begin
        rep_cnt_d = rep_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK_50 or posedge CR) begin
    if (CR) begin
      rep_on_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= 16'd0;
    end else begin
      rep_on_q    <= rep_on_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`else
  logic unused_rep;
  assign unused_rep = REPEAT_DELAY_MS[0] ^ REPEAT_RATE_MS[0];
  assign rep_fire   = 1'b0;
`endif

  // Next state, strobe, idle timer and blink. MODE takes priority over INC.
  always_comb begin
    state_d    = state_q;
    strobe_d   = 5'b00000;
    to_cnt_d   = to_cnt_q;
    bl_cnt_d   = bl_cnt_q;
    bl_phase_d = bl_phase_q;
    fire       = 1'b0;
    if (mode_ev) begin
      state_d  = next_mode(state_q);
      to_cnt_d = 14'd0;
    end else if (is_set) begin
      if (inc_ev || rep_fire) begin
        fire     = 1'b1;
        to_cnt_d = 14'd0;
      end else if (timeout_hit) begin
        state_d  = RUN;
        to_cnt_d = 14'd0;
      end else if (tick_1k) begin
        to_cnt_d = to_cnt_q + 14'd1;
      end
    end
    if (fire) strobe_d = field_of(state_q);
    // Field shown steadily right after entry or adjustment.
    if (state_d != state_q || fire || !is_set) begin
      bl_cnt_d   = 16'd0;
      bl_phase_d = 1'b0;
    end else if (tick_1k) begin
      if (bl_cnt_q + 16'd1 == BL_LIM) begin
        bl_cnt_d   = 16'd0;
        bl_phase_d = ~bl_phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK_50 or posedge CR) begin
    if (CR) begin
      key_s1_q   <= 2'b00;
      key_s2_q   <= 2'b00;
      key_acc_q  <= 2'b00;
      key_arm_q  <= 2'b00;
      db_cnt_q   <= '0;
      state_q    <= RUN;
      strobe_q   <= 5'b00000;
      to_cnt_q   <= 14'd0;
      bl_cnt_q   <= 16'd0;
      bl_phase_q <= 1'b0;
    end else begin
      key_s1_q   <= {inc_key, mode_key};
      key_s2_q   <= key_s1_q;
      key_acc_q  <= key_acc_d;
      key_arm_q  <= key_arm_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      strobe_q   <= strobe_d;
      to_cnt_q   <= to_cnt_d;
      bl_cnt_q   <= bl_cnt_d;
      bl_phase_q <= bl_phase_d;
    end
  end

  assign adj_hr     = strobe_q[4];
  assign adj_min    = strobe_q[3];
  assign year_add   = strobe_q[2];
  assign month_add  = strobe_q[1];
  assign day_add    = strobe_q[0];
  assign setting    = is_set;
  assign flag       = (state_q == SET_YEAR) || (state_q == SET_MON) ||
                      (state_q == SET_DAY);
  assign blink_mask = field_of(state_q) & {5{bl_phase_q}};

endmodule
